// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Latency: n/a (declarations only). Backpressure: n/a.
package uart_pkg;

   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 434;   // 50 MHz / 115200 baud

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

`ifdef UART_RX_MAJORITY_EN
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
`endif

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, byte/status pulses out.
// Latency: n/a (wiring only). Backpressure: none, consumer must take rx_ready pulses as they come.
interface uart_rx_if;
   import uart_pkg::*;

   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_ready;
   logic                 rx_frame_err;
   logic                 rx_busy;

   modport master (output rx, input rx_data, rx_ready, rx_frame_err, rx_busy);
   modport slave  (input rx, output rx_data, rx_ready, rx_frame_err, rx_busy);

endinterface

// File: rtl/uart_rx_sync_ff.sv
// Two-flop synchronizer for asynchronous inputs, reset to a caller-chosen value.
// Latency: 2 clk. Backpressure: none.
module sync_ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rst_val_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= rst_val_i;
         sync_q <= rst_val_i;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 voting around each sample point.
// Latency: rx_ready ~2 + 9.5*CLKS_PER_BIT clk after the start edge. Backpressure: none, pulses are one clk.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic      clk,
   input  logic      reset,
   uart_rx_if.slave  bus
);

   localparam int TW  = $clog2(CLKS_PER_BIT);
   localparam int BCW = $clog2(DATA_BITS);
   localparam logic [TW-1:0]  HALF_TICK = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0]  LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

   logic rx_s;

   sync_ff #(.WIDTH(1)) u_rx_sync (
      .clk       (clk),
      .reset     (reset),
      .rst_val_i (1'b1),
      .d_i       (bus.rx),
      .q_o       (rx_s)
   );

   rx_state_t            state_q;
   logic [TW-1:0]        tick_q;
   logic [TW-1:0]        tick_d;
   logic [BCW-1:0]       bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [DATA_BITS-1:0] data_q;
   logic                 ready_q;
   logic                 ferr_q;
   logic                 busy_q;

   logic in_frame;
   logic at_target;
   logic samp_stb;
   logic samp_bit;

   assign in_frame  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
   assign at_target = (state_q == START) ? (tick_q == HALF_TICK) : (tick_q == LAST_TICK);
   // Counter restarts at the nominal sample point so it never wraps inside a bit.
   assign tick_d    = at_target ? '0 : tick_q + 1'b1;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;
   logic       pend_q;

   // Vote over t-1, t (history) and t+1 (live), so the decision lands one clk late.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= 2'b11;
         pend_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], rx_s};
         pend_q <= in_frame && at_target;
      end
   end

   assign samp_stb = pend_q;
   assign samp_bit = maj3(hist_q[1], hist_q[0], rx_s);
`else
   assign samp_stb = in_frame && at_target;
   assign samp_bit = rx_s;
`endif

   assign shift_d = {samp_bit, shift_q[DATA_BITS-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         ready_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         tick_q  <= tick_d;

         case (state_q)
            IDLE: begin
               tick_q    <= '0;
               bit_cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end

            START: begin
               if (samp_stb) begin
                  if (samp_bit) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end

            DATA: begin
               if (samp_stb) begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= STOP;
                  end
               end
            end

            STOP: begin
               if (samp_stb) begin
                  if (samp_bit) begin
                     data_q  <= shift_q;
                     ready_q <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= WAIT_HIGH;
                  end
               end
            end

            WAIT_HIGH: begin
               // A held break must not be mistaken for a fresh start bit.
               tick_q <= '0;
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data      = data_q;
   assign bus.rx_ready     = ready_q;
   assign bus.rx_frame_err = ferr_q;
   assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; serial stimulus driven on negedge.
module tb_uart_rx;

   localparam int CPB = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_rx_if u_if();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int ready_cnt = 0;
   int ferr_cnt  = 0;
   int both_cnt  = 0;
   int cyc_ready = 0;
   logic [7:0] data_log [0:15];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (u_if.rx_ready) begin
         if (ready_cnt < 16) data_log[ready_cnt] = u_if.rx_data;
         ready_cnt++;
         cyc_ready = cyc;
      end
      if (u_if.rx_frame_err) ferr_cnt++;
      if (u_if.rx_ready && u_if.rx_frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      u_if.rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Spike lands on the clk whose value the nominal sample point sees.
   task automatic send_bit(input logic b, input bit spike);
      for (int c = 0; c < CPB; c++) begin
         u_if.rx = (spike && c == 9) ? ~b : b;
         @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] v, input logic stop_val, input bit spike);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(v[i], spike);
      send_bit(stop_val, 1'b0);
   endtask

   initial begin
      int   r0;
      int   f0;
      int   lat;
      int   t_start;
      logic got_idle;

      u_if.rx = 1'b1;
      reset   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data",  u_if.rx_data,      8'h00);
      check("rst_ready", u_if.rx_ready,     1'b0);
      check("rst_ferr",  u_if.rx_frame_err, 1'b0);
      check("rst_busy",  u_if.rx_busy,      1'b0);
      reset = 1'b0;
      idle(10);
      check("idle_busy", u_if.rx_busy, 1'b0);

      // Single well-formed frame plus latency.
      r0 = ready_cnt; f0 = ferr_cnt; t_start = cyc;
      send_byte(8'hA5, 1'b1, 1'b0);
      idle(20);
      check("a5_pulses", ready_cnt - r0, 1);
      check("a5_log",    data_log[r0], 8'hA5);
      check("a5_data",   u_if.rx_data, 8'hA5);
      check("a5_ferr",   ferr_cnt - f0, 0);
      check("a5_busy",   u_if.rx_busy, 1'b0);
      lat = cyc_ready - t_start - 1;
      checks++;
      assert (lat >= 153 && lat <= 157) else begin
         errors++;
         $error("FAIL a5_latency: observed %0d expected 153..157", lat);
      end

      // Back-to-back frames.
      r0 = ready_cnt;
      send_byte(8'h3C, 1'b1, 1'b0);
      send_byte(8'hFF, 1'b1, 1'b0);
      idle(20);
      check("b2b_pulses", ready_cnt - r0, 2);
      check("b2b_first",  data_log[r0],     8'h3C);
      check("b2b_second", data_log[r0 + 1], 8'hFF);
      check("b2b_data",   u_if.rx_data,     8'hFF);

      // Short low glitch on the idle line.
      r0 = ready_cnt; f0 = ferr_cnt;
      u_if.rx = 1'b0;
      repeat (4) @(negedge clk);
      u_if.rx = 1'b1;
      check("glitch_busy_hi", u_if.rx_busy, 1'b1);
      got_idle = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!u_if.rx_busy) begin
            got_idle = 1'b1;
            break;
         end
      end
      check("glitch_busy_lo", got_idle, 1'b1);
      idle(20);
      check("glitch_ready", ready_cnt - r0, 0);
      check("glitch_ferr",  ferr_cnt - f0, 0);

      // Bad stop bit followed by a long break, then a good frame.
      r0 = ready_cnt; f0 = ferr_cnt;
      send_byte(8'h55, 1'b0, 1'b0);
      u_if.rx = 1'b0;
      repeat (40 * CPB) @(negedge clk);
      check("ferr_pulses", ferr_cnt - f0, 1);
      check("ferr_ready",  ready_cnt - r0, 0);
      check("ferr_hold",   u_if.rx_data, 8'hFF);
      check("ferr_busy",   u_if.rx_busy, 1'b1);
      idle(20);
      check("ferr_release", u_if.rx_busy, 1'b0);
      send_byte(8'h12, 1'b1, 1'b0);
      idle(20);
      check("after_ferr_pulses", ready_cnt - r0, 1);
      check("after_ferr_data",   u_if.rx_data, 8'h12);
      check("after_ferr_ferr",   ferr_cnt - f0, 1);

      // Reset in the middle of bit 4 of 0x81.
      r0 = ready_cnt; f0 = ferr_cnt;
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      u_if.rx = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy",  u_if.rx_busy,  1'b0);
      check("midrst_data",  u_if.rx_data,  8'h00);
      check("midrst_ready", u_if.rx_ready, 1'b0);
      u_if.rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(30);
      check("midrst_nopulse", ready_cnt - r0, 0);
      check("midrst_noferr",  ferr_cnt - f0, 0);
      send_byte(8'h7E, 1'b1, 1'b0);
      idle(20);
      check("postrst_pulses", ready_cnt - r0, 1);
      check("postrst_data",   u_if.rx_data, 8'h7E);

      // One-clk inverted spike at each data bit centre.
      r0 = ready_cnt; f0 = ferr_cnt;
      send_byte(8'h96, 1'b1, 1'b1);
      idle(20);
      check("spike_pulses", ready_cnt - r0, 1);
      check("spike_ferr",   ferr_cnt - f0, 0);
`ifdef UART_RX_MAJORITY_EN
      check("spike_majority", u_if.rx_data, 8'h96);
`else
      check("spike_single",   u_if.rx_data, 8'h69);
`endif

      check("ready_ferr_overlap", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port rx_data, output, 8, last correctly framed byte.
REQ-006 SHALL have port rx_ready, output, 1, one-clk pulse marking rx_data newly valid.
REQ-007 SHALL have port rx_frame_err, output, 1, one-clk pulse on a bad stop bit.
REQ-008 SHALL have port rx_busy, output, 1, high in every state other than IDLE.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer; the FSM uses only the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 IDLE: rx_s==0 -> START, bit counter cleared, sample-tick counter cleared.
REQ-012 START: at tick CLKS_PER_BIT/2 (integer division), sample; 0 -> DATA with tick counter cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-013 DATA: at every tick CLKS_PER_BIT-1, sample into shift register LSB first; after the 8th sample -> STOP.
REQ-014 STOP: at tick CLKS_PER_BIT-1, sample; 1 -> rx_data <= shift register, rx_ready=1 for exactly one clk, -> IDLE.
REQ-015 STOP sample 0 -> rx_frame_err=1 for one clk, rx_data unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s==1 (line break held indefinitely), then -> IDLE; no further pulses while waiting.
REQ-017 rx_data SHALL hold its value between rx_ready pulses; rx_ready and rx_frame_err never assert in the same cycle.
REQ-018 Tick counter width SHALL be $clog2(CLKS_PER_BIT); it never wraps inside a bit (cleared at each sample point).
REQ-019 Latency: rx_ready SHALL assert 2 (synchronizer) + 9.5*CLKS_PER_BIT (+/-1) clks after the rx start edge.
REQ-020 Back-to-back frames (start bit immediately after stop bit) SHALL be received with no byte lost.
REQ-021 rx_ready pulse width one clk makes it safe for a negedge-clocked consumer to sample it exactly once.

Reset
REQ-022 On reset: state IDLE, both synchronizer flops 1, rx_data 8'h00, rx_ready 0, rx_frame_err 0, counters 0, shift register 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; after release a new start edge is required.

Configuration
REQ-024 Macro UART_RX_MAJORITY_EN defined: each sample point uses the 2-of-3 majority of rx_s at ticks t-1, t, t+1 around the nominal point; decision taken at t+1.
REQ-025 Macro undefined: single sample of rx_s at the nominal tick; the majority logic is absent from the netlist.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum typedef (rx_state_t), DATA_BITS=8, and the default CLKS_PER_BIT constant.
REQ-027 Sub-module sync_ff (parameterised two-flop synchronizer with reset value input) SHALL be instantiated for rx.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0xA5 with correct framing -> single rx_ready pulse, rx_data==8'hA5, rx_frame_err never high.
REQ-029 Send 0x3C then 0xFF back-to-back -> two rx_ready pulses, rx_data 8'h3C then 8'hFF.
REQ-030 4-clk low glitch on idle line -> no pulse, rx_busy returns to 0 within 10 clks.
REQ-031 Send 0x55 with stop bit forced 0, line held low 40 bit-times, then high, then 0x12 -> one rx_frame_err pulse, rx_data stays at prior value, then rx_ready with 8'h12.
REQ-032 Assert reset during bit 4 of 0x81, release, send 0x7E -> no pulse for 0x81, rx_ready with 8'h7E.
REQ-033 With UART_RX_MAJORITY_EN: 1-clk inverted spike at each data bit centre of 0x96 -> rx_data==8'h96; without macro, same stimulus -> mismatch detected (expected-failure check).
